// File: rtl/outerprodrc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : outerprodrc_ctrl
//  Description : Chunk sequencer for the outer-product unary GEMM array.
//                Fetches each K chunk from the tile buffer, clears the array
//                once before the first chunk, runs every chunk for a full
//                unary stream length, drains, then pulses done.
//  Revision    : 1.0  initial release
// ============================================================================
module outerprodrc_ctrl #(
  parameter int CYCLEW    = 3,
  parameter int TILEW     = 8,
  parameter int DRAIN_CYC = 2
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iStart,
  input  logic [TILEW-1:0] iKTiles,
  input  logic             iAbort,
  output logic             oFetchReq,
  input  logic             iFetchAck,
  output logic             oLoad,
  output logic             oClr,
  output logic             oEn,
  output logic [TILEW-1:0] oTileIdx,
  output logic             oBusy,
  output logic             oDone
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CLEAR = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Terminal values: last cycle of a chunk's stream and last drain cycle.
  localparam logic [CYCLEW-1:0] CYC_LAST   = '1;
  localparam logic [3:0]        DRAIN_LAST = 4'(DRAIN_CYC - 1);
  localparam logic [TILEW-1:0]  TILE_ONE   = TILEW'(1);

  state_t            state, state_nxt;
  logic [TILEW-1:0]  tile, tile_nxt;
  logic [TILEW-1:0]  k_lat, k_nxt;
  logic [CYCLEW-1:0] cyc, cyc_nxt;
  logic [3:0]        drain, drain_nxt;

  // State and counter registers; async reset returns everything to idle/zero.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state <= S_IDLE;
      tile  <= '0;
      k_lat <= '0;
      cyc   <= '0;
      drain <= '0;
    end else begin
      state <= state_nxt;
      tile  <= tile_nxt;
      k_lat <= k_nxt;
      cyc   <= cyc_nxt;
      drain <= drain_nxt;
    end
  end

  // Next-state/counter logic and state-decoded outputs; abort overrides all.
  always_comb begin
    state_nxt = state;
    tile_nxt  = tile;
    k_nxt     = k_lat;
    cyc_nxt   = cyc;
    drain_nxt = drain;

    oFetchReq = 1'b0;
    oLoad     = 1'b0;
    oClr      = 1'b0;
    oEn       = 1'b0;
    oDone     = 1'b0;
    oBusy     = (state != S_IDLE);
    oTileIdx  = tile;

    case (state)
      S_IDLE: begin
        // A zero-length job is dropped without any handshake.
        if (iStart && (iKTiles != '0)) begin
          k_nxt     = iKTiles;
          tile_nxt  = '0;
          cyc_nxt   = '0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        oFetchReq = 1'b1;
        oLoad     = iFetchAck;
        if (iFetchAck) begin
          cyc_nxt   = '0;
          // Only the first chunk clears, so accumulators sum across chunks.
          state_nxt = (tile == '0) ? S_CLEAR : S_RUN;
        end
      end
      S_CLEAR: begin
        oClr      = 1'b1;
        cyc_nxt   = '0;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        oEn     = 1'b1;
        cyc_nxt = cyc + 1'b1;
        if (cyc == CYC_LAST) begin
          if (tile == (k_lat - TILE_ONE)) begin
            drain_nxt = '0;
            state_nxt = S_DRAIN;
          end else begin
            tile_nxt  = tile + TILE_ONE;
            state_nxt = S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        drain_nxt = drain + 1'b1;
        if (drain == DRAIN_LAST) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        oDone     = 1'b1;
        tile_nxt  = '0;
        cyc_nxt   = '0;
        drain_nxt = '0;
        state_nxt = S_IDLE;
      end
      default: begin
        tile_nxt  = '0;
        cyc_nxt   = '0;
        drain_nxt = '0;
        state_nxt = S_IDLE;
      end
    endcase

    // Abort wins over everything; strobes this cycle still follow the state.
    if (iAbort) begin
      state_nxt = S_IDLE;
      tile_nxt  = '0;
      k_nxt     = '0;
      cyc_nxt   = '0;
      drain_nxt = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_outerprodrc_ctrl.sv
`timescale 1ns/1ps
module tb_outerprodrc_ctrl;

  localparam int CYCLEW    = 3;
  localparam int TILEW     = 8;
  localparam int DRAIN_CYC = 2;
  localparam int RUNLEN    = 1 << CYCLEW;
  localparam int NOLIMIT   = 32'h7fff_ffff;

  logic             iClk = 1'b0;
  logic             iRstN = 1'b0;
  logic             iStart = 1'b0;
  logic [TILEW-1:0] iKTiles = '0;
  logic             iAbort = 1'b0;
  logic             iFetchAck = 1'b0;
  logic             oFetchReq, oLoad, oClr, oEn, oBusy, oDone;
  logic [TILEW-1:0] oTileIdx;

  outerprodrc_ctrl #(.CYCLEW(CYCLEW), .TILEW(TILEW), .DRAIN_CYC(DRAIN_CYC)) dut (
    .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .iKTiles(iKTiles),
    .iAbort(iAbort), .oFetchReq(oFetchReq), .iFetchAck(iFetchAck),
    .oLoad(oLoad), .oClr(oClr), .oEn(oEn), .oTileIdx(oTileIdx),
    .oBusy(oBusy), .oDone(oDone)
  );

  always #5 iClk = ~iClk;

  // Expected busy-cycle trace: flags are {req, load, clr, en, done}.
  typedef struct {
    int         cyc;
    logic [4:0] flags;
    logic [7:0] tile;
  } ev_t;

  ev_t exp_q[$];
  int  cycle = 0;
  int  checks = 0;
  int  errors = 0;
  int  ack_delay = 0;
  bit  ack_always = 1'b0;
  int  req_cnt = 0;

  always @(posedge iClk) cycle <= cycle + 1;

  // Buffer model: ack after ack_delay waiting cycles, or tied high.
  always @(posedge iClk) begin
    #2;
    if (oFetchReq) req_cnt = req_cnt + 1;
    else           req_cnt = 0;
    iFetchAck = ack_always || (oFetchReq && (req_cnt > ack_delay));
  end

  // Monitor: every busy cycle must match the head of the expected trace.
  always @(negedge iClk) begin
    logic [4:0] f;
    ev_t        e;
    f = {oFetchReq, oLoad, oClr, oEn, oDone};
    while (exp_q.size() != 0 && exp_q[0].cyc < cycle) begin
      e = exp_q.pop_front();
      checks++; errors++;
      $display("FAIL missing_event: cyc=%0d not seen, required flags=%b tile=%0d", e.cyc, e.flags, e.tile);
    end
    if (oBusy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_busy: cyc=%0d flags=%b tile=%0d, required idle", cycle, f, oTileIdx);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cycle || e.flags != f || e.tile != oTileIdx) begin
          errors++;
          $display("FAIL trace: got cyc=%0d flags(req,load,clr,en,done)=%b tile=%0d, required cyc=%0d flags=%b tile=%0d",
                   cycle, f, oTileIdx, e.cyc, e.flags, e.tile);
        end
      end
    end else if (f != 5'b0) begin
      checks++; errors++;
      $display("FAIL idle_strobe: cyc=%0d flags=%b, required 00000", cycle, f);
    end
    checks++;
    if ($countones({oLoad, oClr, oEn}) > 1) begin
      errors++;
      $display("FAIL exclusive: cyc=%0d load/clr/en=%b, required at most one", cycle, {oLoad, oClr, oEn});
    end
  end

  function automatic void push(int c, logic [4:0] f, int t, int limit);
    if (c <= limit) exp_q.push_back('{c, f, 8'(t)});
  endfunction

  // Hand schedule of one job starting (iStart high) in cycle s; returns done cycle.
  function automatic int model_job(int s, int k, int d, int limit);
    int c;
    c = s + 1;
    for (int t = 0; t < k; t++) begin
      for (int i = 0; i <= d; i++) begin
        push(c, (i == d) ? 5'b11000 : 5'b10000, t, limit);
        c++;
      end
      if (t == 0) begin
        push(c, 5'b00100, 0, limit);
        c++;
      end
      for (int i = 0; i < RUNLEN; i++) begin
        push(c, 5'b00010, t, limit);
        c++;
      end
    end
    for (int i = 0; i < DRAIN_CYC; i++) begin
      push(c, 5'b00000, k - 1, limit);
      c++;
    end
    push(c, 5'b00001, k - 1, limit);
    return c;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic wait_cyc(int n);
    int guard;
    guard = 0;
    while (cycle < n && guard < 5000) begin
      @(posedge iClk);
      #1;
      guard++;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int d1;
    int d2;

    // Reset values while held in reset
    #3;
    chk("rst_busy", oBusy, 0);
    chk("rst_req", oFetchReq, 0);
    chk("rst_load", oLoad, 0);
    chk("rst_clr", oClr, 0);
    chk("rst_en", oEn, 0);
    chk("rst_done", oDone, 0);
    chk("rst_tile", oTileIdx, 0);
    @(posedge iClk); @(posedge iClk); #3;
    iRstN = 1'b1;

    // K=2, ack tied high (also high outside FETCH)
    ack_always = 1'b1;
    s = 5;
    wait_cyc(s);
    iKTiles = 8'd2; iStart = 1'b1;
    d1 = model_job(s, 2, 0, NOLIMIT);
    wait_cyc(s + 1); iStart = 1'b0;
    wait_cyc(d1 + 1);
    chk("k2_busy_after_done", oBusy, 0);
    ack_always = 1'b0;

    // Start with K=0 is ignored
    s = d1 + 3;
    wait_cyc(s);
    iKTiles = 8'd0; iStart = 1'b1;
    wait_cyc(s + 1); iStart = 1'b0;
    chk("k0_busy", oBusy, 0);
    wait_cyc(s + 3);
    chk("k0_busy_later", oBusy, 0);

    // K=1, ack after 5 waiting cycles, start pulses during RUN ignored
    ack_delay = 5;
    s = s + 5;
    wait_cyc(s);
    iKTiles = 8'd1; iStart = 1'b1;
    d1 = model_job(s, 1, 5, NOLIMIT);
    wait_cyc(s + 1); iStart = 1'b0;
    wait_cyc(s + 10); iStart = 1'b1;
    wait_cyc(s + 11); iStart = 1'b0;
    wait_cyc(s + 13); iStart = 1'b1;
    wait_cyc(s + 14); iStart = 1'b0;
    wait_cyc(d1 + 1);
    chk("dly_busy_after_done", oBusy, 0);
    ack_delay = 0;

    // K=3, abort in 4th RUN cycle of chunk 1, then a full job
    s = d1 + 3;
    wait_cyc(s);
    iKTiles = 8'd3; iStart = 1'b1;
    d1 = model_job(s, 3, 0, s + 15);
    wait_cyc(s + 1); iStart = 1'b0;
    wait_cyc(s + 15); iAbort = 1'b1;
    wait_cyc(s + 16); iAbort = 1'b0;
    chk("abort_busy", oBusy, 0);
    chk("abort_en", oEn, 0);
    chk("abort_tile", oTileIdx, 0);
    s = s + 19;
    wait_cyc(s);
    iStart = 1'b1;
    d1 = model_job(s, 3, 0, NOLIMIT);
    wait_cyc(s + 1); iStart = 1'b0;
    wait_cyc(d1 + 1);
    chk("abort_rerun_idle", oBusy, 0);

    // Async reset mid-FETCH (buffer never acks)
    ack_delay = 1000;
    s = d1 + 3;
    wait_cyc(s);
    iKTiles = 8'd2; iStart = 1'b1;
    push(s + 1, 5'b10000, 0, NOLIMIT);
    push(s + 2, 5'b10000, 0, NOLIMIT);
    wait_cyc(s + 1); iStart = 1'b0;
    wait_cyc(s + 3);
    #2; iRstN = 1'b0; #1;
    chk("arst_busy", oBusy, 0);
    chk("arst_req", oFetchReq, 0);
    chk("arst_tile", oTileIdx, 0);
    @(posedge iClk); #3; iRstN = 1'b1;
    ack_delay = 0;
    s = cycle + 2;
    wait_cyc(s);
    iStart = 1'b1;
    d1 = model_job(s, 2, 0, NOLIMIT);
    wait_cyc(s + 1); iStart = 1'b0;
    wait_cyc(d1 + 1);
    chk("arst_rerun_idle", oBusy, 0);

    // Back-to-back jobs with iStart held high
    s = d1 + 3;
    wait_cyc(s);
    iKTiles = 8'd1; iStart = 1'b1;
    d1 = model_job(s, 1, 0, NOLIMIT);
    d2 = model_job(d1 + 1, 1, 0, NOLIMIT);
    wait_cyc(d2); iStart = 1'b0;
    wait_cyc(d2 + 2);
    chk("b2b_idle", oBusy, 0);

    repeat (3) @(posedge iClk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
